// File: rtl/ysyx_22050550_wbu.sv
// Writeback/commit stage: retires one instruction per handshake, drives the GPR write port,
// performs Zicsr read-modify-write, ecall trap entry (two cycles) and mret with fetch redirect.
module ysyx_22050550_wbu (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [4:0]  in_rd,
    input  logic        in_rdwen,
    input  logic [63:0] in_result,
    input  logic [2:0]  in_op,
    input  logic [11:0] in_csraddr,
    input  logic [63:0] in_rs1data,
    input  logic [63:0] mepc,
    input  logic [63:0] mcause,
    input  logic [63:0] mtvec,
    input  logic [63:0] mstatus,
    input  logic [63:0] mie,
    input  logic [63:0] mip,
    output logic [4:0]  io_waddr,
    output logic [63:0] io_wdata,
    output logic        io_wen,
    output logic        io_valid,
    output logic [63:0] pc,
    output logic [63:0] wbmepc,
    output logic [63:0] wbmcause,
    output logic [63:0] wbmtvec,
    output logic [63:0] wbmstatus,
    output logic [63:0] wbmie,
    output logic [63:0] wbmip,
    output logic [7:0]  wbcsren,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        TRAP   = 2'd2
    } state_t;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_CSRRW = 3'd1;
    localparam logic [2:0] OP_CSRRS = 3'd2;
    localparam logic [2:0] OP_CSRRC = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    // Index order matches the wbcsren bit order.
    localparam logic [11:0] CSR_ADDR [6] = '{12'h341, 12'h342, 12'h305, 12'h300, 12'h304, 12'h344};

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, result_reg, rs1data_reg;
    logic [4:0]  rd_reg;
    logic        rdwen_reg;
    logic [2:0]  op_reg;
    logic [11:0] csraddr_reg;
    logic        transfer;

    assign in_ready = !reset && ((state_reg == IDLE) ||
                                 ((state_reg == COMMIT) && (op_reg != OP_ECALL)));
    assign transfer = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            pc_reg      <= '0;
            result_reg  <= '0;
            rs1data_reg <= '0;
            rd_reg      <= '0;
            rdwen_reg   <= 1'b0;
            op_reg      <= OP_NONE;
            csraddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (transfer) begin
                pc_reg      <= in_pc;
                result_reg  <= in_result;
                rs1data_reg <= in_rs1data;
                rd_reg      <= in_rd;
                rdwen_reg   <= in_rdwen;
                // Reserved encodings 6/7 retire as plain instructions.
                op_reg      <= (in_op > OP_MRET) ? OP_NONE : in_op;
                csraddr_reg <= in_csraddr;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (transfer) state_next = COMMIT;
            COMMIT: begin
                if (op_reg == OP_ECALL) state_next = TRAP;
                else if (transfer)      state_next = COMMIT;
                else                    state_next = IDLE;
            end
            TRAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic [63:0] csr_cur [6];
    logic [5:0]  csr_sel;
    logic [63:0] csr_old, csr_new;

    assign csr_cur[0] = mepc;
    assign csr_cur[1] = mcause;
    assign csr_cur[2] = mtvec;
    assign csr_cur[3] = mstatus;
    assign csr_cur[4] = mie;
    assign csr_cur[5] = mip;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_csr_sel
            assign csr_sel[gi] = (csraddr_reg == CSR_ADDR[gi]);
        end
    endgenerate

    always_comb begin
        csr_old = '0;
        for (int i = 0; i < 6; i++) begin
            if (csr_sel[i]) csr_old = csr_old | csr_cur[i];
        end
        case (op_reg)
            OP_CSRRW: csr_new = rs1data_reg;
            OP_CSRRS: csr_new = csr_old | rs1data_reg;
            OP_CSRRC: csr_new = csr_old & ~rs1data_reg;
            default:  csr_new = '0;
        endcase
    end

    // Trap entry stacks MIE into MPIE; mret restores it. Only M-mode exists, so MPP stays 2'b11.
    logic [63:0] mstatus_trap, mstatus_mret;
    always_comb begin
        mstatus_trap        = mstatus;
        mstatus_trap[7]     = mstatus[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
        mstatus_mret        = mstatus;
        mstatus_mret[3]     = mstatus[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;
    end

    logic [63:0] wb_val [6];

    always_comb begin
        io_waddr       = '0;
        io_wdata       = '0;
        io_wen         = 1'b0;
        io_valid       = 1'b0;
        pc             = '0;
        wbcsren        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < 6; i++) wb_val[i] = '0;
        if (!reset) begin
            case (state_reg)
                COMMIT: begin
                    case (op_reg)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                            io_valid = 1'b1;
                            pc       = pc_reg;
                            io_waddr = rd_reg;
                            io_wdata = csr_old;
                            io_wen   = (rd_reg != 5'd0);
                            for (int i = 0; i < 6; i++) begin
                                if (csr_sel[i]) wb_val[i] = csr_new;
                            end
                            wbcsren  = {2'b00, csr_sel};
                        end
                        OP_ECALL: begin
                            wb_val[0] = pc_reg;
                            wb_val[1] = 64'd11;
                            wbcsren   = 8'h03;
                        end
                        OP_MRET: begin
                            io_valid       = 1'b1;
                            pc             = pc_reg;
                            wb_val[3]      = mstatus_mret;
                            wbcsren        = 8'h08;
                            redirect_valid = 1'b1;
                            redirect_pc    = mepc;
                        end
                        default: begin
                            io_valid = 1'b1;
                            pc       = pc_reg;
                            io_waddr = rd_reg;
                            io_wdata = result_reg;
                            io_wen   = rdwen_reg && (rd_reg != 5'd0);
                        end
                    endcase
                end
                TRAP: begin
                    io_valid       = 1'b1;
                    pc             = pc_reg;
                    wb_val[3]      = mstatus_trap;
                    wbcsren        = 8'h08;
                    redirect_valid = 1'b1;
                    redirect_pc    = mtvec & ~64'h3;
                end
                default: ;
            endcase
        end
    end

    assign wbmepc    = wb_val[0];
    assign wbmcause  = wb_val[1];
    assign wbmtvec   = wb_val[2];
    assign wbmstatus = wb_val[3];
    assign wbmie     = wb_val[4];
    assign wbmip     = wb_val[5];

endmodule

// File: tb/tb_ysyx_22050550_wbu.sv
// Scoreboard bench for the writeback stage: each scenario pushes the expected per-cycle
// output snapshot when it drives stimulus and compares it once the DUT presents that cycle.
module tb_ysyx_22050550_wbu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rdwen;
    logic [63:0] in_result;
    logic [2:0]  in_op;
    logic [11:0] in_csraddr;
    logic [63:0] in_rs1data;
    logic [63:0] mepc, mcause, mtvec, mstatus, mie, mip;
    logic [4:0]  io_waddr;
    logic [63:0] io_wdata;
    logic        io_wen;
    logic        io_valid;
    logic [63:0] pc;
    logic [63:0] wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip;
    logic [7:0]  wbcsren;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ysyx_22050550_wbu dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
        .in_rdwen(in_rdwen), .in_result(in_result), .in_op(in_op),
        .in_csraddr(in_csraddr), .in_rs1data(in_rs1data),
        .mepc(mepc), .mcause(mcause), .mtvec(mtvec), .mstatus(mstatus), .mie(mie), .mip(mip),
        .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wen(io_wen), .io_valid(io_valid), .pc(pc),
        .wbmepc(wbmepc), .wbmcause(wbmcause), .wbmtvec(wbmtvec), .wbmstatus(wbmstatus),
        .wbmie(wbmie), .wbmip(wbmip), .wbcsren(wbcsren),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        in_ready;
        logic        io_wen;
        logic [4:0]  io_waddr;
        logic [63:0] io_wdata;
        logic        io_valid;
        logic [63:0] pc;
        logic [7:0]  wbcsren;
        logic [63:0] wbmepc;
        logic [63:0] wbmcause;
        logic [63:0] wbmtvec;
        logic [63:0] wbmstatus;
        logic [63:0] wbmie;
        logic [63:0] wbmip;
        logic        redirect_valid;
        logic [63:0] redirect_pc;
    } obs_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // GPR index/data are only meaningful while the write enable is high.
    function automatic obs_t snap();
        obs_t o;
        o.in_ready       = in_ready;
        o.io_wen         = io_wen;
        o.io_waddr       = io_wen ? io_waddr : 5'd0;
        o.io_wdata       = io_wen ? io_wdata : 64'd0;
        o.io_valid       = io_valid;
        o.pc             = pc;
        o.wbcsren        = wbcsren;
        o.wbmepc         = wbmepc;
        o.wbmcause       = wbmcause;
        o.wbmtvec        = wbmtvec;
        o.wbmstatus      = wbmstatus;
        o.wbmie          = wbmie;
        o.wbmip          = wbmip;
        o.redirect_valid = redirect_valid;
        o.redirect_pc    = redirect_pc;
        return o;
    endfunction

    function automatic obs_t idle_exp();
        obs_t o = '0;
        o.in_ready = 1'b1;
        return o;
    endfunction

    function automatic obs_t commit_exp(input logic [63:0] p);
        obs_t o = '0;
        o.in_ready = 1'b1;
        o.io_valid = 1'b1;
        o.pc       = p;
        return o;
    endfunction

    function automatic obs_t alu_exp(input logic [63:0] p, input logic [4:0] rd,
                                     input logic we, input logic [63:0] res);
        obs_t o = commit_exp(p);
        if (we && rd != 5'd0) begin
            o.io_wen   = 1'b1;
            o.io_waddr = rd;
            o.io_wdata = res;
        end
        return o;
    endfunction

    function automatic obs_t csr_exp(input logic [2:0] op, input logic [11:0] a, input logic [4:0] rd,
                                     input logic [63:0] rs1, input logic [63:0] p);
        obs_t        o = commit_exp(p);
        logic [63:0] old = '0;
        logic [63:0] nv;
        case (a)
            12'h341: old = mepc;
            12'h342: old = mcause;
            12'h305: old = mtvec;
            12'h300: old = mstatus;
            12'h304: old = mie;
            12'h344: old = mip;
            default: old = '0;
        endcase
        if (op == 3'd1)      nv = rs1;
        else if (op == 3'd2) nv = old | rs1;
        else                 nv = old & ~rs1;
        if (rd != 5'd0) begin
            o.io_wen   = 1'b1;
            o.io_waddr = rd;
            o.io_wdata = old;
        end
        case (a)
            12'h341: begin o.wbmepc    = nv; o.wbcsren = 8'h01; end
            12'h342: begin o.wbmcause  = nv; o.wbcsren = 8'h02; end
            12'h305: begin o.wbmtvec   = nv; o.wbcsren = 8'h04; end
            12'h300: begin o.wbmstatus = nv; o.wbcsren = 8'h08; end
            12'h304: begin o.wbmie     = nv; o.wbcsren = 8'h10; end
            12'h344: begin o.wbmip     = nv; o.wbcsren = 8'h20; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic drive(input logic v, input logic [63:0] p, input logic [4:0] rd, input logic we,
                         input logic [63:0] res, input logic [2:0] op, input logic [11:0] a,
                         input logic [63:0] rs1);
        in_valid   = v;
        in_pc      = p;
        in_rd      = rd;
        in_rdwen   = we;
        in_result  = res;
        in_op      = op;
        in_csraddr = a;
        in_rs1data = rs1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        obs_t obs, e;
        reset = 1'b1;
        drive(1'b1, 64'h80000000, 5'd5, 1'b1, 64'h55, 3'd0, 12'h0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back('0);
            tick();
            obs = snap();
            e   = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL test_reset[%0d] got=%h want=%h", k, obs, e);
            end else $display("test_reset[%0d] ok", k);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        sb_q.push_back(idle_exp());
        #1;
        obs = snap();
        e   = sb_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL test_reset_release got=%h want=%h", obs, e);
        end else $display("test_reset_release ok");
    endtask

    task automatic test_alu();
        obs_t        obs, e;
        logic [63:0] t_pc  [4] = '{64'h80000000, 64'h80000004, 64'h80000008, 64'h8000000c};
        logic [4:0]  t_rd  [4] = '{5'd5, 5'd0, 5'd8, 5'd10};
        logic        t_we  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] t_res [4] = '{64'h1234, 64'h99, 64'h77, 64'hCAFE_F00D_0000_0001};
        logic [2:0]  t_op  [4] = '{3'd0, 3'd0, 3'd0, 3'd6};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t_pc[i], t_rd[i], t_we[i], t_res[i], t_op[i], 12'h300, 64'hFF);
            sb_q.push_back(alu_exp(t_pc[i], t_rd[i], t_we[i], t_res[i]));
            sb_q.push_back(idle_exp());
            for (int k = 0; k < 2; k++) begin
                tick();
                if (k == 0) in_valid = 1'b0;
                obs = snap();
                e   = sb_q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL test_alu[%0d.%0d] got=%h want=%h", i, k, obs, e);
                end else $display("test_alu[%0d.%0d] ok", i, k);
            end
        end
    endtask

    task automatic test_csr();
        obs_t        obs, e;
        logic [2:0]  t_op  [7] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd1, 3'd3, 3'd1};
        logic [11:0] t_a   [7] = '{12'h300, 12'h341, 12'h304, 12'h344, 12'h7C0, 12'h342, 12'h305};
        logic [4:0]  t_rd  [7] = '{5'd7, 5'd0, 5'd2, 5'd4, 5'd3, 5'd1, 5'd9};
        logic [63:0] t_rs1 [7] = '{64'h8, 64'h1111, 64'h0F, 64'h0, 64'h55, 64'h3, 64'h80000000};
        mepc    = 64'hDEAD;
        mcause  = 64'hF;
        mtvec   = 64'h1;
        mstatus = 64'hA00001800;
        mie     = 64'hFF;
        mip     = 64'h80;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 64'h80001000 + 64'(i * 4), t_rd[i], 1'b0, 64'h0, t_op[i], t_a[i], t_rs1[i]);
            sb_q.push_back(csr_exp(t_op[i], t_a[i], t_rd[i], t_rs1[i], 64'h80001000 + 64'(i * 4)));
            sb_q.push_back(idle_exp());
            for (int k = 0; k < 2; k++) begin
                tick();
                if (k == 0) in_valid = 1'b0;
                obs = snap();
                e   = sb_q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL test_csr[%0d.%0d] got=%h want=%h", i, k, obs, e);
                end else $display("test_csr[%0d.%0d] ok", i, k);
            end
        end
    endtask

    task automatic test_ecall();
        obs_t obs, e;
        mtvec   = 64'h80000203;
        mstatus = 64'hA00001808;
        drive(1'b1, 64'h80000100, 5'd0, 1'b0, 64'h0, 3'd4, 12'h0, 64'h0);
        e = '0;
        e.wbcsren  = 8'h03;
        e.wbmepc   = 64'h80000100;
        e.wbmcause = 64'd11;
        sb_q.push_back(e);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) begin
                // Next instruction waits upstream while the trap completes.
                drive(1'b1, 64'h80000200, 5'd6, 1'b1, 64'h77, 3'd0, 12'h0, 64'h0);
                e = '0;
                e.wbmstatus      = 64'hA00001880;
                e.wbcsren        = 8'h08;
                e.redirect_valid = 1'b1;
                e.redirect_pc    = 64'h80000200;
                e.io_valid       = 1'b1;
                e.pc             = 64'h80000100;
                sb_q.push_back(e);
                sb_q.push_back(idle_exp());
                sb_q.push_back(alu_exp(64'h80000200, 5'd6, 1'b1, 64'h77));
            end
            if (k == 3) begin
                in_valid = 1'b0;
                sb_q.push_back(idle_exp());
            end
            obs = snap();
            e   = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL test_ecall[%0d] got=%h want=%h", k, obs, e);
            end else $display("test_ecall[%0d] ok", k);
        end
    endtask

    task automatic test_mret();
        obs_t        obs, e;
        logic [63:0] t_mepc [2] = '{64'h80000104, 64'h80000400};
        logic [63:0] t_ms   [2] = '{64'hA00001880, 64'h8};
        logic [63:0] t_want [2] = '{64'hA00001888, 64'h1880};
        for (int i = 0; i < 2; i++) begin
            mepc    = t_mepc[i];
            mstatus = t_ms[i];
            drive(1'b1, 64'h80000300, 5'd4, 1'b1, 64'h12, 3'd5, 12'h0, 64'h0);
            e = commit_exp(64'h80000300);
            e.wbmstatus      = t_want[i];
            e.wbcsren        = 8'h08;
            e.redirect_valid = 1'b1;
            e.redirect_pc    = t_mepc[i];
            sb_q.push_back(e);
            sb_q.push_back(idle_exp());
            for (int k = 0; k < 2; k++) begin
                tick();
                if (k == 0) in_valid = 1'b0;
                obs = snap();
                e   = sb_q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL test_mret[%0d.%0d] got=%h want=%h", i, k, obs, e);
                end else $display("test_mret[%0d.%0d] ok", i, k);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t        obs, e;
        logic [4:0]  t_rd  [4] = '{5'd1, 5'd0, 5'd31, 5'd12};
        logic        t_we  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] t_res [4] = '{64'hA, 64'hB, 64'hFFFF_FFFF_FFFF_FFFF, 64'hD};
        logic [2:0]  t_op  [4] = '{3'd0, 3'd0, 3'd6, 3'd7};
        drive(1'b1, 64'h1000, t_rd[0], t_we[0], t_res[0], t_op[0], 12'h0, 64'h0);
        sb_q.push_back(alu_exp(64'h1000, t_rd[0], t_we[0], t_res[0]));
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 3) begin
                drive(1'b1, 64'h1000 + 64'((k + 1) * 4), t_rd[k+1], t_we[k+1], t_res[k+1],
                      t_op[k+1], 12'h0, 64'h0);
                sb_q.push_back(alu_exp(64'h1000 + 64'((k + 1) * 4), t_rd[k+1], t_we[k+1], t_res[k+1]));
            end else if (k == 3) begin
                in_valid = 1'b0;
                sb_q.push_back(idle_exp());
            end
            obs = snap();
            e   = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL test_back_to_back[%0d] got=%h want=%h", k, obs, e);
            end else $display("test_back_to_back[%0d] ok", k);
        end
    endtask

    task automatic test_reset_trap();
        obs_t obs, e;
        mtvec   = 64'h80000203;
        mstatus = 64'hA00001808;
        drive(1'b1, 64'h80000500, 5'd0, 1'b0, 64'h0, 3'd4, 12'h0, 64'h0);
        e = '0;
        e.wbcsren  = 8'h03;
        e.wbmepc   = 64'h80000500;
        e.wbmcause = 64'd11;
        sb_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) in_valid = 1'b0;
            if (k == 1) begin
                // Now in the TRAP cycle: reset must suppress every output immediately.
                reset = 1'b1;
                #1;
                sb_q.push_back('0);
            end
            if (k == 2) begin
                reset = 1'b0;
                #1;
                sb_q.push_back(idle_exp());
            end
            if (k == 3) sb_q.push_back(idle_exp());
            obs = snap();
            e   = sb_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL test_reset_trap[%0d] got=%h want=%h", k, obs, e);
            end else $display("test_reset_trap[%0d] ok", k);
        end
    endtask

    initial begin
        reset   = 1'b1;
        mepc    = '0;
        mcause  = '0;
        mtvec   = '0;
        mstatus = '0;
        mie     = '0;
        mip     = '0;
        drive(1'b0, 64'h0, 5'd0, 1'b0, 64'h0, 3'd0, 12'h0, 64'h0);
        test_reset();
        test_alu();
        test_csr();
        test_ecall();
        test_mret();
        test_back_to_back();
        test_reset_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
